// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and types for the FIR output path
package fir_pkg;
   localparam int DATA_W         = 10;
   localparam int FILTER_LATENCY = 11;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef enum logic {WARM, RUN} state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
// A push while full is still accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      level <= level + 1'b1;
         else if (!do_push && do_pop) level <= level - 1'b1;
      end
   end
endmodule

// File: rtl/fir_out_decim.sv
// rtl/fir_out_decim.sv - FIR output stage: warm-up discard, decimation, FIFO
// Samples pass through bit-exact; only the kept ones enter the FIFO.
module fir_out_decim #(
   parameter int DATA_W = fir_pkg::DATA_W,
   parameter int DECIM  = 4,
   parameter int WARMUP = fir_pkg::FILTER_LATENCY,
   parameter int DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          y_in,
   input  logic                       clr_ovf,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf
);
   import fir_pkg::*;

   localparam logic [7:0] WARM_LAST  = 8'((WARMUP > 0) ? WARMUP - 1 : 0);
   localparam logic [4:0] DECIM_LAST = 5'(DECIM - 1);

   state_t     state;
   logic [7:0] warm_cnt;
   logic [4:0] phase;
   logic       keep;
   logic       pop;
   logic       full;
   logic       empty;

   assign keep      = (state == RUN) && (phase == '0);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= (WARMUP == 0) ? RUN : WARM;
         warm_cnt <= '0;
         phase    <= '0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            WARM: begin
               // The edge that reaches WARM_LAST still discards its sample.
               if (warm_cnt == WARM_LAST) state <= RUN;
               else                       warm_cnt <= warm_cnt + 1'b1;
            end
            RUN: phase <= (phase == DECIM_LAST) ? 5'd0 : phase + 1'b1;
            default: state <= WARM;
         endcase
         if (keep && full && !pop) ovf <= 1'b1;
         else if (clr_ovf)         ovf <= 1'b0;
      end
   end

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (keep),
      .pop   (pop),
      .din   (y_in),
      .dout  (out_data),
      .level (level),
      .full  (full),
      .empty (empty)
   );
endmodule

// File: tb/tb_fir_out_decim.sv
// tb/tb_fir_out_decim.sv - scoreboard bench for fir_out_decim
// u_a runs defaults (DECIM=4, WARMUP=11); u_b runs DECIM=1, WARMUP=0.
module tb_fir_out_decim;
   import fir_pkg::*;

   logic          clk;
   logic          rst_a, rst_b;
   sample_t       y_a, y_b;
   logic          clr_a, clr_b;
   logic [9:0]    d_a, d_b;
   logic          v_a, v_b;
   logic          r_a, r_b;
   logic [3:0]    lvl_a, lvl_b;
   logic          ovf_a, ovf_b;

   int checks   = 0;
   int failures = 0;
   sample_t q_a[$];
   sample_t q_b[$];

   fir_out_decim u_a (
      .clk(clk), .rst(rst_a), .y_in(y_a), .clr_ovf(clr_a),
      .out_data(d_a), .out_valid(v_a), .out_ready(r_a), .level(lvl_a), .ovf(ovf_a)
   );

   fir_out_decim #(.DATA_W(10), .DECIM(1), .WARMUP(0), .DEPTH(8)) u_b (
      .clk(clk), .rst(rst_b), .y_in(y_b), .clr_ovf(clr_b),
      .out_data(d_b), .out_valid(v_b), .out_ready(r_b), .level(lvl_b), .ovf(ovf_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (v_a && r_a) begin
         sample_t e;
         checks++;
         if (q_a.size() == 0) begin
            failures++;
            $display("FAIL a_unexpected: got %0d expected none", $signed(d_a));
         end else begin
            e = q_a.pop_front();
            if (d_a !== e) begin
               failures++;
               $display("FAIL a_data: got %0d expected %0d", $signed(d_a), e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (v_b && r_b) begin
         sample_t e;
         checks++;
         if (q_b.size() == 0) begin
            failures++;
            $display("FAIL b_unexpected: got %0d expected none", $signed(d_b));
         end else begin
            e = q_b.pop_front();
            if (d_b !== e) begin
               failures++;
               $display("FAIL b_data: got %0d expected %0d", $signed(d_b), e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input sample_t v, input bit exp_keep);
      y_a = v;
      if (exp_keep) q_a.push_back(v);
      tick();
   endtask

   task automatic drive_b(input sample_t v, input bit exp_keep);
      y_b = v;
      if (exp_keep) q_b.push_back(v);
      tick();
   endtask

   // FIFO contents are lost on reset, so pending expectations go too.
   task automatic reset_b();
      rst_b = 1'b1;
      tick();
      q_b.delete();
      rst_b = 1'b0;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      y_a = '0; y_b = '0;
      clr_a = 1'b0; clr_b = 1'b0;
      r_a = 1'b1; r_b = 1'b0;
      tick();
      chk("rst_valid", v_a, 0);
      chk("rst_level", lvl_a, 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_data", d_a, 0);

      // Warm-up discard then keep 1 of 4: 11, 15, 19, ...
      rst_a = 1'b0;
      for (int k = 0; k <= 40; k++)
         drive_a(sample_t'(k), (k >= 11) && (((k - 11) % 4) == 0));
      chk("a_ovf_after_ramp", ovf_a, 0);
      chk("a_drained", q_a.size(), 0);

      // Fill to 5 with the consumer stalled, then reset mid-cycle.
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      r_a = 1'b0;
      for (int k = 0; k <= 27; k++) drive_a(sample_t'(k), 1'b0);
      chk("a_level5", lvl_a, 5);
      @(negedge clk);
      #2 rst_a = 1'b1;
      #1;
      chk("async_level", lvl_a, 0);
      chk("async_valid", v_a, 0);
      chk("async_ovf", ovf_a, 0);
      tick();
      rst_a = 1'b0;
      r_a = 1'b1;
      for (int k = 0; k <= 22; k++)
         drive_a(sample_t'(100 + k), (k >= 11) && (((k - 11) % 4) == 0));
      chk("a_post_reset_drained", q_a.size(), 0);
      rst_a = 1'b1;

      // Signed extremes pass through bit-exact.
      r_b = 1'b1;
      reset_b();
      for (int k = 0; k < 3; k++) drive_b(-10'sd512, 1'b1);
      for (int k = 0; k < 3; k++) drive_b(10'sd511, 1'b1);

      // Overflow, clear priority, full-with-pop acceptance.
      r_b = 1'b0;
      reset_b();
      for (int k = 0; k < 8; k++) drive_b(sample_t'(k), 1'b1);
      chk("b_level_full", lvl_b, 8);
      chk("b_ovf_before_drop", ovf_b, 0);
      drive_b(sample_t'(8), 1'b0);
      chk("b_ovf_set", ovf_b, 1);
      chk("b_level_hold", lvl_b, 8);
      clr_b = 1'b1;
      drive_b(sample_t'(9), 1'b0);
      chk("b_ovf_set_wins", ovf_b, 1);
      r_b = 1'b1;
      drive_b(sample_t'(10), 1'b1);
      clr_b = 1'b0;
      chk("b_ovf_cleared", ovf_b, 0);
      chk("b_level_full_pop", lvl_b, 8);
      for (int k = 11; k <= 19; k++) drive_b(sample_t'(k), 1'b1);
      chk("b_level_steady", lvl_b, 8);
      chk("b_ovf_stays_clear", ovf_b, 0);
      chk("b_pending", q_b.size(), 8);
      reset_b();
      rst_b = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
